// File: rtl/serial_pkg.sv
// Shared types and constants for the serial frame receiver.
// Provides the FSM state enum, line levels and a clog2 helper.
package serial_pkg;

  typedef enum logic [2:0] {
    IDLE,
    DATA,
    PARITY,
    STOP,
    BREAK
  } state_t;

  localparam logic LINE_IDLE = 1'b1;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;
  localparam int   DEFAULT_DATA_W = 8;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/serial_byte_rx_if.sv
// Ready/valid word channel out of the serial receiver.
// master: drives out/valid, takes ready; slave: the consumer.
interface serial_byte_rx_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] out;
  logic              valid;
  logic              ready;

  modport master (
    output out,
    output valid,
    input  ready
  );

  modport slave (
    input  out,
    input  valid,
    output ready
  );
endinterface

// File: rtl/serial_shift_in.sv
// DATA_W-bit right shift register; new bit enters at the MSB.
// Ports: clk, rst_n, clr, en, din in; q out (LSB-first word).
module serial_shift_in #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              en,
  input  logic              din,
  output logic [DATA_W-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (en) begin
      q <= {din, q[DATA_W-1:1]};
    end
  end

endmodule

// File: rtl/serial_byte_rx.sv
// Bit-serial frame receiver with a one-word ready/valid buffer.
// Ports: clk, rst_n, in0 line; bus (out/valid/ready) master;
// frame_err, overrun pulses; parity_err with SERIAL_RX_PARITY_EN.
module serial_byte_rx
  import serial_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in0,
  serial_byte_rx_if.master bus,
  output logic             frame_err,
`ifdef SERIAL_RX_PARITY_EN
  output logic             parity_err,
`endif
  output logic             overrun
);

  localparam int CW = clog2(DATA_W);
  localparam logic [CW-1:0] LAST = CW'(DATA_W - 1);

  state_t            state;
  logic [CW-1:0]     bit_cnt;
  logic [DATA_W-1:0] word;
  logic              good;
  logic              ferr;
  logic              shift_en;
  logic              shift_clr;
`ifdef SERIAL_RX_PARITY_EN
  logic              pbad;
  logic              perr;
`endif

  assign shift_en  = (state == DATA);
  assign shift_clr = (state == IDLE) && (in0 == START_BIT);

  serial_shift_in #(
    .DATA_W(DATA_W)
  ) u_shift (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (shift_clr),
    .en   (shift_en),
    .din  (in0),
    .q    (word)
  );

  // Frame outcome is staged in good/ferr for one cycle, so the
  // buffer and error pulses all update on the edge after stop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      good      <= 1'b0;
      ferr      <= 1'b0;
      bus.out   <= '0;
      bus.valid <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
`ifdef SERIAL_RX_PARITY_EN
      pbad       <= 1'b0;
      perr       <= 1'b0;
      parity_err <= 1'b0;
`endif
    end else begin
      good      <= 1'b0;
      ferr      <= 1'b0;
      frame_err <= ferr;
      overrun   <= 1'b0;
`ifdef SERIAL_RX_PARITY_EN
      perr       <= 1'b0;
      parity_err <= perr;
`endif
      // A load on a handshake edge wins over the clear.
      if (good) begin
        if (!bus.valid || bus.ready) begin
          bus.out   <= word;
          bus.valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (bus.valid && bus.ready) begin
        bus.valid <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (in0 == START_BIT) begin
            state   <= DATA;
            bit_cnt <= '0;
          end
        end
        DATA: begin
          bit_cnt <= bit_cnt + 1'b1;
          if (bit_cnt == LAST) begin
            bit_cnt <= '0;
`ifdef SERIAL_RX_PARITY_EN
            state <= PARITY;
`else
            state <= STOP;
`endif
          end
        end
`ifdef SERIAL_RX_PARITY_EN
        PARITY: begin
          pbad  <= (^word) ^ in0;
          state <= STOP;
        end
`endif
        STOP: begin
          if (in0 == STOP_BIT) begin
            state <= IDLE;
`ifdef SERIAL_RX_PARITY_EN
            if (pbad) perr <= 1'b1;
            else      good <= 1'b1;
`else
            good <= 1'b1;
`endif
          end else begin
            ferr  <= 1'b1;
            state <= BREAK;
          end
        end
        // Wait out a held-low line so it is not
        // mistaken for a run of start bits.
        BREAK: begin
          if (in0 == LINE_IDLE) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/serial_byte_rx.md
Name: serial_byte_rx

Overview:
- Bit-serial frame receiver; the consuming end of the single-wire serial link driven by the team's serial transmitter.
- Samples one line bit per clock, strips start/stop framing and presents each received word on a ready/valid output with a one-entry holding buffer.
- Sits between a gate-level line driver and any word-wide consumer (register file, counter, ALU input).

Parameters:
- DATA_W, 8, data bits per frame, sent LSB first; legal range 2..16.

Ports:
- clk  input  1  single clock; everything samples on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in0  input  1  serial line; idles high.
- ready  input  1  consumer accepts the word when ready and valid are both high on an edge.
- out  output  DATA_W  received word, stable while valid is high.
- valid  output  1  out holds an unconsumed word.
- frame_err  output  1  one-cycle pulse: stop bit sampled low.
- overrun  output  1  one-cycle pulse: good frame dropped because the buffer was full.

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, bit_cnt=0, shift=0, out=0, valid=0, frame_err=0, overrun=0. Deasserting reset mid-frame abandons the partial frame; reception restarts from IDLE.
- Frame format: start bit 0, DATA_W data bits LSB first, stop bit 1. One bit per clock, no oversampling.
- States:
  - IDLE: in0=0 -> DATA with bit_cnt=0; otherwise stay.
  - DATA: shift in0 into MSB of shift (shift right), bit_cnt+1. After DATA_W bits -> STOP (-> PARITY when the optional feature is built).
  - STOP: in0=1 -> good frame, -> IDLE. in0=0 -> frame_err pulses on the next cycle, frame is discarded, -> BREAK.
  - BREAK: stay until in0=1, then -> IDLE. Held-low lines must not be read as back-to-back start bits.
- Good frame: if the buffer is empty, or valid and ready are both high in the same cycle, load out and set valid on the edge after the stop bit is sampled. Latency is DATA_W+2 clocks from the start-bit edge to valid. Otherwise keep the old out, drop the new word, and pulse overrun for one cycle.
- Back-to-back frames: a start bit is accepted in the cycle immediately after STOP (from IDLE), so there is zero idle gap.
- valid clears on a ready&valid edge unless a new word loads on that same edge; the load wins and valid stays high.
- out never changes while valid=1 and ready=0.
- frame_err and overrun are never asserted together.

Optional Feature:
- Macro: SERIAL_RX_PARITY_EN.
- Defined:
  - PARITY state sits between DATA and STOP and samples one even-parity bit.
  - Extra output parity_err (1 bit), a one-cycle pulse when the XOR of data bits and parity bit is 1. It is reported one cycle after stop.
  - A frame with a parity error is discarded like a framing error, but the FSM returns to IDLE, not BREAK.
  - If the stop bit is also low, frame_err takes precedence and parity_err stays low.
  - Latency becomes DATA_W+3.
- Undefined: no parity_err port, no PARITY state.

Decomposition:
- Shared package serial_pkg:
  - state enum {IDLE, DATA, PARITY, STOP, BREAK}, with PARITY present in all builds.
  - constants LINE_IDLE=1, START_BIT=0, STOP_BIT=1, DEFAULT_DATA_W=8.
  - function clog2 for the bit_cnt width.
- One natural sub-module, serial_shift_in: DATA_W-bit shift register with shift-enable and clear. The FSM, buffer and flags stay in serial_byte_rx.

Test Plan:
- Reset then word 0xA5: line 0,1,0,1,0,0,1,0,1,1 with ready=1 -> out=0xA5, valid=1 for exactly one cycle, 10 clocks after the start bit; no error pulses.
- Stop bit low: frame 0x3C then line held 0 for 4 clocks, then 1 -> frame_err one pulse, valid stays 0, no false start; next frame 0x01 is received correctly.
- Overrun: ready=0, frames 0x11 then 0x22 back-to-back -> out=0x11 and valid held; overrun pulses once after the second stop bit; ready=1 later yields 0x11 only.
- Same-edge load: first word pending, ready rises on the same edge the next stop bit completes -> out switches to the new word, valid stays 1, no overrun.
- Reset mid-frame: rst_n low after 4 data bits, released, then frame 0xFF -> out=0xFF with no residue from the partial frame.
- With SERIAL_RX_PARITY_EN: 0x07 with parity 1 -> accepted; same word with parity 0 -> parity_err pulse, valid 0.
